// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the 64-bit Y86 SEQ datapath.
//   - register ID encodings (RRAX..RR14, RRSP, RNONE)
//   - NUM_REGS  : number of architectural program registers
//   - WORD_W    : machine word width
//   - reg_bank_t: packed view of the whole register bank, used to hand the
//                 storage to the read-port muxes in one connection
// ---------------------------------------------------------------------------
package y86_pkg;

   localparam int WORD_W   = 64;
   localparam int NUM_REGS = 15;

   typedef logic [3:0] reg_id_t;

   localparam reg_id_t RRAX  = 4'h0;
   localparam reg_id_t RRCX  = 4'h1;
   localparam reg_id_t RRDX  = 4'h2;
   localparam reg_id_t RRBX  = 4'h3;
   localparam reg_id_t RRSP  = 4'h4;
   localparam reg_id_t RRBP  = 4'h5;
   localparam reg_id_t RRSI  = 4'h6;
   localparam reg_id_t RRDI  = 4'h7;
   localparam reg_id_t RR8   = 4'h8;
   localparam reg_id_t RR9   = 4'h9;
   localparam reg_id_t RR10  = 4'hA;
   localparam reg_id_t RR11  = 4'hB;
   localparam reg_id_t RR12  = 4'hC;
   localparam reg_id_t RR13  = 4'hD;
   localparam reg_id_t RR14  = 4'hE;
   localparam reg_id_t RNONE = 4'hF;

   typedef logic [NUM_REGS-1:0][WORD_W-1:0] reg_bank_t;

   // True when the ID names real storage (anything but RNONE).
   function automatic logic is_real_reg(input reg_id_t id);
      return (id != RNONE);
   endfunction

endpackage

// File: rtl/regfile_64_if.sv
// ---------------------------------------------------------------------------
// regfile_64_if
// Bundles the decode read ports, the writeback commit ports, the halt
// handshake and the debug read port of the register file.
//   master : writeback/decode side (drives IDs, write data, wr_en, halt)
//   slave  : register file side   (drives valA/valB/dbg_val/halted)
// clk and rst are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface regfile_64_if;
   import y86_pkg::*;

   reg_id_t             srcA;
   reg_id_t             srcB;
   logic [WORD_W-1:0]   valA;
   logic [WORD_W-1:0]   valB;
   reg_id_t             dstE;
   logic [WORD_W-1:0]   valE;
   reg_id_t             dstM;
   logic [WORD_W-1:0]   valM;
   logic                wr_en;
   logic                halt;
   logic                halted;
   reg_id_t             dbg_sel;
   logic [WORD_W-1:0]   dbg_val;

   modport master (
      output srcA, srcB, dstE, valE, dstM, valM, wr_en, halt, dbg_sel,
      input  valA, valB, halted, dbg_val
   );

   modport slave (
      input  srcA, srcB, dstE, valE, dstM, valM, wr_en, halt, dbg_sel,
      output valA, valB, halted, dbg_val
   );

endinterface

// File: rtl/regfile_rdport_64.sv
// ---------------------------------------------------------------------------
// regfile_rdport_64
// Combinational 15:1 read mux over the register bank. RNONE (and any ID that
// does not name storage) reads as zero.
// Ports:
//   i_regs : whole register bank
//   i_sel  : register ID to read
//   o_val  : selected register contents (0 for RNONE)
// ---------------------------------------------------------------------------
module regfile_rdport_64
   import y86_pkg::*;
(
   input  reg_bank_t          i_regs,
   input  reg_id_t            i_sel,
   output logic [WORD_W-1:0]  o_val
);

   // Compare against every real ID instead of indexing with i_sel directly,
   // so RNONE can never reach past the end of the bank.
   always_comb begin
      o_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i_sel == reg_id_t'(i)) begin
            o_val = i_regs[i];
         end
      end
   end

endmodule

// File: rtl/regfile_64.sv
// ---------------------------------------------------------------------------
// regfile_64
// Architectural register file of the 64-bit Y86 SEQ core. Holds %rax..%r14,
// commits the writeback E and M ports on the rising edge and serves two
// zero-latency read ports to decode plus a debug read port.
// Parameters:
//   DATA_W   : register width, fixed at 64 for this core
//   RSP_INIT : reset value of %rsp
// Ports:
//   clk  : system clock, all updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_64_if.slave
//          srcA/srcB -> valA/valB   decode read ports
//          dstE/valE, dstM/valM     writeback commit ports
//          wr_en                    commit qualifier
//          halt -> halted           sticky halt, blocks all later writes
//          dbg_sel -> dbg_val       debug read port
// Reads do not bypass same-cycle writes: a register written this cycle still
// reads its old value until the edge.
// ---------------------------------------------------------------------------
module regfile_64
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
)
(
   input  logic           clk,
   input  logic           rst,
   regfile_64_if.slave    bus
);

   reg_bank_t  r_regs;
   logic       r_halted;
   logic       w_commit;

   // wr_en gates everything first, so X on the write IDs or data while
   // wr_en is low cannot reach the storage enables.
   assign w_commit = bus.wr_en & ~r_halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (reg_id_t'(i) == RRSP) ? RSP_INIT : '0;
         end
         r_halted <= 1'b0;
      end else if (w_commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // M port is checked first so it wins a same-register collision
            // (popq %rsp must leave the popped value, not the incremented SP).
            if (is_real_reg(bus.dstM) && bus.dstM == reg_id_t'(i)) begin
               r_regs[i] <= bus.valM;
            end else if (is_real_reg(bus.dstE) && bus.dstE == reg_id_t'(i)) begin
               r_regs[i] <= bus.valE;
            end
         end
         // The halting instruction's own writes commit in the same edge.
         if (bus.halt) begin
            r_halted <= 1'b1;
         end
      end
   end

   assign bus.halted = r_halted;

   regfile_rdport_64 u_rd_a (
      .i_regs (r_regs),
      .i_sel  (bus.srcA),
      .o_val  (bus.valA)
   );

   regfile_rdport_64 u_rd_b (
      .i_regs (r_regs),
      .i_sel  (bus.srcB),
      .o_val  (bus.valB)
   );

   regfile_rdport_64 u_rd_dbg (
      .i_regs (r_regs),
      .i_sel  (bus.dbg_sel),
      .o_val  (bus.dbg_val)
   );

endmodule

// File: tb/tb_regfile_64.sv
module tb_regfile_64;
   import y86_pkg::*;

   localparam logic [63:0] RSP_RST = 64'h100;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   // Reference model: plain array of 16 words, entry 15 is never written.
   logic [63:0] m_regs [0:15];
   logic        m_halted;

   regfile_64_if bus ();

   regfile_64 #(.DATA_W(64), .RSP_INIT(RSP_RST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_rd(input logic [3:0] id);
      return (id == 4'hF) ? 64'h0 : m_regs[id];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 64'h0;
      m_regs[4] = RSP_RST;
      m_halted  = 1'b0;
   endtask

   task automatic drive_idle();
      bus.srcA = 4'hF; bus.srcB = 4'hF; bus.dbg_sel = 4'hF;
      bus.dstE = 4'hF; bus.dstM = 4'hF;
      bus.valE = 64'h0; bus.valM = 64'h0;
      bus.wr_en = 1'b0; bus.halt = 1'b0;
   endtask

   // Apply the current inputs across one rising edge; the model follows the
   // architectural rules: M applied after E, nothing when halted or wr_en=0.
   task automatic tick();
      if (bus.wr_en && !m_halted) begin
         if (bus.dstE != 4'hF) m_regs[bus.dstE] = bus.valE;
         if (bus.dstM != 4'hF) m_regs[bus.dstM] = bus.valM;
         if (bus.halt) m_halted = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Fill every register with something non-zero first.
      for (int i = 0; i < 15; i++) begin
         bus.dstE = 4'(i); bus.valE = {$urandom, $urandom} | 64'h1;
         bus.wr_en = 1'b1;
         tick();
      end
      drive_idle();
      bus.srcA = 4'h4; bus.srcB = 4'h0; bus.dbg_sel = 4'hE;
      #2;
      rst = 1'b1;                 // mid-cycle, no edge follows before checks
      model_reset();
      #1;
      n_vec++;
      if (bus.valA !== RSP_RST) begin
         n_err++; $display("FAIL reset_rsp_async: got %h want %h", bus.valA, RSP_RST);
      end
      n_vec++;
      if (bus.valB !== 64'h0) begin
         n_err++; $display("FAIL reset_r0_async: got %h want 0", bus.valB);
      end
      n_vec++;
      if (bus.dbg_val !== 64'h0) begin
         n_err++; $display("FAIL reset_r14_async: got %h want 0", bus.dbg_val);
      end
      n_vec++;
      if (bus.halted !== 1'b0) begin
         n_err++; $display("FAIL reset_halted: got %b want 0", bus.halted);
      end
      for (int i = 0; i < 15; i++) begin
         bus.dbg_sel = 4'(i);
         #1;
         n_vec++;
         if (bus.dbg_val !== ((i == 4) ? RSP_RST : 64'h0)) begin
            n_err++; $display("FAIL reset_bank r%0d: got %h", i, bus.dbg_val);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_dual_write();
      drive_idle();
      bus.dstE = 4'd3; bus.valE = 64'hAAAA;
      bus.dstM = 4'd5; bus.valM = 64'h5555;
      bus.wr_en = 1'b1;
      tick();
      drive_idle();
      bus.srcA = 4'd3; bus.srcB = 4'd5;
      #1;
      n_vec++;
      if (bus.valA !== 64'hAAAA || bus.valB !== 64'h5555) begin
         n_err++; $display("FAIL dual_write: got r3=%h r5=%h want aaaa 5555", bus.valA, bus.valB);
      end
      for (int i = 0; i < 15; i++) begin
         bus.dbg_sel = 4'(i);
         #0.5;
         n_vec++;
         if (bus.dbg_val !== ref_rd(4'(i))) begin
            n_err++; $display("FAIL dual_write_bank r%0d: got %h want %h", i, bus.dbg_val, ref_rd(4'(i)));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_collision();
      drive_idle();
      bus.dstE = 4'd4; bus.valE = 64'h1F8;
      bus.dstM = 4'd4; bus.valM = 64'hDEAD;
      bus.wr_en = 1'b1;
      tick();
      drive_idle();
      bus.srcA = 4'd4;
      #1;
      n_vec++;
      if (bus.valA !== 64'hDEAD) begin
         n_err++; $display("FAIL collision_m_wins: got %h want dead", bus.valA);
      end
   endtask

   task automatic test_read_during_write();
      drive_idle();
      bus.dstE = 4'd2; bus.valE = 64'd7; bus.wr_en = 1'b1;
      tick();
      bus.srcA = 4'd2; bus.dstE = 4'd2; bus.valE = 64'd9;
      #1;
      n_vec++;
      if (bus.valA !== 64'd7) begin
         n_err++; $display("FAIL rdw_before_edge: got %h want 7", bus.valA);
      end
      tick();
      n_vec++;
      if (bus.valA !== 64'd9) begin
         n_err++; $display("FAIL rdw_after_edge: got %h want 9", bus.valA);
      end
      drive_idle();
      #1;
   endtask

   task automatic test_rnone();
      drive_idle();
      #1;
      n_vec++;
      if (bus.valA !== 64'h0 || bus.valB !== 64'h0) begin
         n_err++; $display("FAIL rnone_read: got %h %h want 0 0", bus.valA, bus.valB);
      end
      bus.dstE = 4'hF; bus.valE = 64'h1234_5678_9ABC_DEF0;
      bus.dstM = 4'hF; bus.valM = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.wr_en = 1'b1;
      tick();
      drive_idle();
      for (int i = 0; i < 16; i++) begin
         bus.dbg_sel = 4'(i);
         #0.5;
         n_vec++;
         if (bus.dbg_val !== ref_rd(4'(i))) begin
            n_err++; $display("FAIL rnone_write r%0d: got %h want %h", i, bus.dbg_val, ref_rd(4'(i)));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_halt();
      // halt without wr_en is ignored
      drive_idle();
      bus.halt = 1'b1; bus.dstE = 4'd1; bus.valE = 64'h33;
      tick();
      n_vec++;
      if (bus.halted !== 1'b0) begin
         n_err++; $display("FAIL halt_no_wr_en: got %b want 0", bus.halted);
      end
      bus.wr_en = 1'b1; bus.valE = 64'h42;
      tick();
      bus.srcA = 4'd1;
      #1;
      n_vec++;
      if (bus.valA !== 64'h42 || bus.halted !== 1'b1) begin
         n_err++; $display("FAIL halt_commit: got r1=%h halted=%b want 42 1", bus.valA, bus.halted);
      end
      bus.halt = 1'b0; bus.valE = 64'h99;
      bus.dstM = 4'd6; bus.valM = 64'h77;
      tick();
      bus.srcB = 4'd6;
      #1;
      n_vec++;
      if (bus.valA !== 64'h42 || bus.valB !== ref_rd(4'd6)) begin
         n_err++; $display("FAIL halt_blocks: got r1=%h r6=%h want 42 %h", bus.valA, bus.valB, ref_rd(4'd6));
      end
      drive_idle();
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if (bus.halted !== 1'b0) begin
         n_err++; $display("FAIL halt_cleared: got %b want 0", bus.halted);
      end
      rst = 1'b0;
      bus.dstE = 4'd1; bus.valE = 64'h77; bus.wr_en = 1'b1; bus.srcA = 4'd1;
      tick();
      n_vec++;
      if (bus.valA !== 64'h77) begin
         n_err++; $display("FAIL write_after_halt_reset: got %h want 77", bus.valA);
      end
      drive_idle();
      #1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bus.srcA    = 4'($urandom_range(0, 15));
         bus.srcB    = 4'($urandom_range(0, 15));
         bus.dbg_sel = 4'($urandom_range(0, 15));
         bus.dstE    = 4'($urandom_range(0, 15));
         bus.dstM    = ($urandom_range(0, 3) == 0) ? bus.dstE : 4'($urandom_range(0, 15));
         bus.valE    = {$urandom, $urandom};
         bus.valM    = {$urandom, $urandom};
         bus.wr_en   = ($urandom_range(0, 3) != 0);
         bus.halt    = ($urandom_range(0, 39) == 0);
         #1;
         n_vec++;
         if (bus.valA !== ref_rd(bus.srcA) || bus.valB !== ref_rd(bus.srcB) ||
             bus.dbg_val !== ref_rd(bus.dbg_sel)) begin
            n_err++;
            $display("FAIL random_read it%0d: A[%0d]=%h/%h B[%0d]=%h/%h D[%0d]=%h/%h", n,
                     bus.srcA, bus.valA, ref_rd(bus.srcA), bus.srcB, bus.valB, ref_rd(bus.srcB),
                     bus.dbg_sel, bus.dbg_val, ref_rd(bus.dbg_sel));
         end
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            model_reset();
            #1;
            rst = 1'b0;
         end
         tick();
         n_vec++;
         if (bus.halted !== m_halted) begin
            n_err++; $display("FAIL random_halted it%0d: got %b want %b", n, bus.halted, m_halted);
         end
      end
      drive_idle();
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drive_idle();
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_dual_write();
      test_collision();
      test_read_during_write();
      test_rnone();
      test_halt();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
